// File: rtl/v_issue_ctrl.sv
// Vector issue sequencer: 2-entry instruction queue feeding v_inst_decode, one op in flight.
// Optional performance counters are compiled in when V_ISSUE_PERF_EN is defined.
module v_issue_ctrl #(
    parameter int VINST_W   = 32,
    parameter int MEM_LAT   = 2,
    parameter int LONG_LAT  = 4,
    parameter int SHORT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid_i,
    input  logic [VINST_W-1:0] inst_i,
    output logic               inst_ready_o,
    input  logic               flush_i,
    output logic               issue_valid_o,
    output logic [VINST_W-1:0] issue_inst_o,
    output logic               done_o,
    output logic               busy_o,
    output logic               illegal_o
`ifdef V_ISSUE_PERF_EN
    ,
    output logic [31:0]        perf_issue_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    localparam logic [6:0] OPCODE_VL  = 7'b0000111;
    localparam logic [6:0] OPCODE_VS  = 7'b0100111;
    localparam logic [6:0] OPCODE_VEC = 7'b1010111;
    localparam logic [2:0] FUNCT3_IVV = 3'b000;

    // Custom accelerator ops live in the upper funct6 space of OPIVV.
    localparam logic [5:0] FUNCT6_CONV1 = 6'b100000;
    localparam logic [5:0] FUNCT6_CONV2 = 6'b100001;
    localparam logic [5:0] FUNCT6_POOL1 = 6'b100010;
    localparam logic [5:0] FUNCT6_POOL2 = 6'b100011;
    localparam logic [5:0] FUNCT6_FC1   = 6'b100100;

    localparam int MAX_A   = (MEM_LAT > LONG_LAT) ? MEM_LAT : LONG_LAT;
    localparam int MAX_LAT = (MAX_A > SHORT_LAT) ? MAX_A : SHORT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    logic [VINST_W-1:0] q_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         q_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         state;

    logic [VINST_W-1:0] head;
    logic [6:0]         head_opcode;
    logic [2:0]         head_funct3;
    logic [5:0]         head_funct6;
    logic               head_long;
    logic               head_legal;
    logic [CNT_W-1:0]   head_lat;

    logic q_empty;
    logic q_full;
    logic push;
    logic issue_fire;
    logic drop_fire;
    logic pop;

    assign head        = q_mem[rd_ptr];
    assign head_opcode = head[6:0];
    assign head_funct3 = head[14:12];
    assign head_funct6 = head[31:26];
    assign q_empty     = (q_cnt == 2'd0);
    assign q_full      = (q_cnt == 2'd2);

    always_comb begin
        head_long  = 1'b0;
        head_legal = 1'b0;
        head_lat   = CNT_W'(SHORT_LAT);
        if (head_funct3 == FUNCT3_IVV &&
            (head_funct6 == FUNCT6_CONV1 || head_funct6 == FUNCT6_CONV2 ||
             head_funct6 == FUNCT6_POOL1 || head_funct6 == FUNCT6_POOL2 ||
             head_funct6 == FUNCT6_FC1)) begin
            head_long = 1'b1;
        end
        if (head_opcode == OPCODE_VL || head_opcode == OPCODE_VS) begin
            head_legal = 1'b1;
            head_lat   = CNT_W'(MEM_LAT);
        end else if (head_opcode == OPCODE_VEC) begin
            head_legal = 1'b1;
            head_lat   = head_long ? CNT_W'(LONG_LAT) : CNT_W'(SHORT_LAT);
        end
    end

    always_comb begin
        state = ST_IDLE;
        if (cnt == CNT_W'(1)) begin
            state = ST_LAST;
        end else if (cnt != '0) begin
            state = ST_EXEC;
        end
    end

    // An illegal head is dropped without waiting for the in-flight op to drain.
    assign issue_fire = !q_empty && !flush_i && head_legal && (cnt <= CNT_W'(1));
    assign drop_fire  = !q_empty && !flush_i && !head_legal;
    assign pop        = issue_fire || drop_fire;
    assign push       = inst_valid_i && !q_full && !flush_i;

    assign inst_ready_o = !q_full;
    assign busy_o       = !q_empty || (cnt != '0);
    assign done_o       = (state == ST_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= inst_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            q_cnt  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            q_cnt  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            issue_valid_o <= 1'b0;
            issue_inst_o  <= '0;
            illegal_o     <= 1'b0;
        end else begin
            illegal_o <= drop_fire;
            if (issue_fire) begin
                cnt           <= head_lat;
                issue_valid_o <= 1'b1;
                issue_inst_o  <= head;
            end else begin
                issue_valid_o <= 1'b0;
                issue_inst_o  <= '0;
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef V_ISSUE_PERF_EN
    logic stall_cond;
    assign stall_cond = !q_empty && head_legal && (cnt > CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt_o <= 32'd0;
            perf_stall_cnt_o <= 32'd0;
        end else begin
            if (issue_fire) begin
                perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
            end
            if (stall_cond) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
